ptp_rx_dispatch: RTL and testbench
==================================

Name: ptp_rx_dispatch

Overview:
- Upstream neighbour of the PTP engine. Sits between the port-side receive path and two consumers:
  - the PTP engine's inptp_* input;
  - the normal switching datapath.
- Inspects each 134-bit packet stream. Steers PTP frames (EtherType 0x88F7, optionally behind one 802.1Q tag) to the PTP channel and all other frames to the normal channel.
- Forwards the packet-end valid descriptor on the channel the packet went to, and counts per-class traffic and protocol errors.

Parameters:
- PTP_ETYPE, 16'h88F7, EtherType that selects the PTP channel.
- VLAN_TPID, 16'h8100, TPID that triggers the second-word EtherType lookup.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- in_data_wr  in  1  input word strobe
- in_data  in  134  [133:132] position (01 head, 11 middle, 10 tail); [131:128] invalid byte count of the tail; [127:0] bytes, byte0 at [127:120]
- in_valid_wr  in  1  packet descriptor strobe, at or after the tail word
- in_valid  in  1  1 = packet good, 0 = discard
- in_ready  out  1  upstream may start a new packet
- ptp_data_wr, ptp_data, ptp_valid_wr, ptp_valid  out  1/134/1/1  to PTP engine
- ptp_ready  in  1  PTP engine has room for one max-size packet
- norm_data_wr, norm_data, norm_valid_wr, norm_valid  out  1/134/1/1  to switching datapath
- norm_ready  in  1  normal path has room for one max-size packet
- ptp_pkt_cnt  out  32  PTP packets forwarded
- norm_pkt_cnt  out  32  non-PTP packets forwarded
- err_cnt  out  32  protocol errors

Behaviour:
- Reset values: all outputs 0; state IDLE; hold register empty.
- Ready:
  - in_ready is a register, set the cycle after (ptp_ready & norm_ready) is seen high.
  - Upstream samples in_ready only before a head word, so in_ready is never back-pressure inside a packet.
- Datapath: a single 134-bit hold register.
  - Each accepted word enters hold.
  - The previous hold word is emitted, registered, on the selected channel when the next word of the same packet arrives.
  - A tail word in hold is emitted on the following cycle (the FLUSH state) without needing further input.
- Classification (EtherType at bytes 12–13 is in_data[31:16]):
  - If in_data[31:16] == PTP_ETYPE on the head word: class PTP.
  - Else if it equals VLAN_TPID: class is decided on word1 from in_data[127:112] (bytes 16–17); PTP if equal to PTP_ETYPE, else NORM.
  - Else: class NORM.
  - The class is always fixed before the head is emitted, so no extra buffering is needed.
- States:
  - IDLE: waits for a head word. A non-head word is dropped and err_cnt increments.
  - HEAD: head is in hold, class pending (VLAN case) or known.
  - BODY: class known; 1-word delay pipeline.
  - FLUSH: the tail is emitted.
  - DESC: waits for in_valid_wr if it has not already been captured; then pulses *_valid_wr with *_valid = in_valid on the selected channel, one cycle after the tail is emitted; returns to IDLE.
- in_valid_wr arriving in the same cycle as the tail, or in any cycle before DESC, is latched into a pending flag.
- Counters:
  - ptp_pkt_cnt or norm_pkt_cnt increments when the descriptor is emitted, regardless of in_valid.
  - All counters wrap at 2^32.
- Error: a head word arriving in HEAD or BODY.
  - Hold is emitted with position forced to 10 (tail), followed by a descriptor with valid = 0.
  - err_cnt increments.
  - The new head is taken as a fresh packet; its classification restarts.
- Simultaneous events: a tail emit and a new head arrival in the same cycle are legal; the new head enters hold.
- Reset asserted mid-packet: everything clears immediately; no partial tail or descriptor is emitted after reset.

Decomposition:
- Shared package ptp_pkg holds:
  - position codes POS_HEAD, POS_MID, POS_TAIL;
  - PTP_ETYPE and VLAN_TPID defaults;
  - word field offsets.
- One natural sub-module: ptp_etype_classify, a combinational function of (word, word_index) returning {decided, is_ptp}.

Test Plan:
- Untagged 4-word frame, in_data[31:16] = 16'h88F7, in_valid = 1 -> 4 words on ptp_* with 1-word delay, tail emitted in FLUSH, ptp_valid_wr = 1 / ptp_valid = 1, ptp_pkt_cnt = 1; norm_* silent.
- Tagged frame, head [31:16] = 16'h8100, word1 [127:112] = 16'h88F7 -> routed to ptp_*; tagged frame with word1 [127:112] = 16'h0800 -> routed to norm_*, norm_pkt_cnt = 1.
- IPv4 frame with in_valid = 0, descriptor arriving 3 cycles after the tail -> norm_valid_wr pulses with norm_valid = 0 one cycle after the descriptor; norm_pkt_cnt increments.
- Head word injected in the middle of a PTP frame -> truncated PTP packet ends in position 10 with ptp_valid = 0; err_cnt = 1; following frame classified correctly.
- ptp_ready = 0 -> in_ready = 0 one cycle later; ptp_ready = 1 -> in_ready = 1 one cycle later; MID word in IDLE -> dropped, err_cnt + 1.
- Reset pulsed during word 2 of a frame -> all outputs 0, no descriptor emitted; next clean frame is forwarded normally.

Source files
------------

// File: rtl/ptp_pkg.sv
// ptp_pkg: shared position codes, EtherType defaults, field offsets and FSM states
package ptp_pkg;
    localparam int W         = 134;
    localparam int POS_MSB   = 133;
    localparam int POS_LSB   = 132;
    localparam int ETYPE_LSB = 16;
    localparam int VTYPE_LSB = 112;
    localparam logic [1:0] POS_HEAD = 2'b01;
    localparam logic [1:0] POS_MID  = 2'b11;
    localparam logic [1:0] POS_TAIL = 2'b10;
    localparam logic [15:0] PTP_ETYPE_DEF = 16'h88F7;
    localparam logic [15:0] VLAN_TPID_DEF = 16'h8100;
    typedef enum logic [2:0] {S_IDLE, S_HEAD, S_BODY, S_FLUSH, S_DESC} state_t;
endpackage

// File: rtl/ptp_etype_classify.sv
// ptp_etype_classify: decides PTP vs normal from the head word or the word after a VLAN tag
module ptp_etype_classify #(
    parameter logic [15:0] PTP_ETYPE = 16'h88F7,
    parameter logic [15:0] VLAN_TPID = 16'h8100
) (
    input  logic [15:0] i_etype,
    input  logic [15:0] i_vtype,
    input  logic        i_idx,
    output logic        o_decided,
    output logic        o_is_ptp
);
    // A tagged head defers the decision to word1, which always settles it
    assign o_decided = i_idx | (i_etype != VLAN_TPID);
    assign o_is_ptp  = i_idx ? (i_vtype == PTP_ETYPE) : (i_etype == PTP_ETYPE);
endmodule

// File: rtl/ptp_rx_dispatch.sv
// ptp_rx_dispatch: steers packets to the PTP or normal channel through a one-word hold register
module ptp_rx_dispatch
    import ptp_pkg::*;
#(
    parameter logic [15:0] PTP_ETYPE = PTP_ETYPE_DEF,
    parameter logic [15:0] VLAN_TPID = VLAN_TPID_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_data_wr,
    input  logic [133:0] in_data,
    input  logic         in_valid_wr,
    input  logic         in_valid,
    output logic         in_ready,
    output logic         ptp_data_wr,
    output logic [133:0] ptp_data,
    output logic         ptp_valid_wr,
    output logic         ptp_valid,
    input  logic         ptp_ready,
    output logic         norm_data_wr,
    output logic [133:0] norm_data,
    output logic         norm_valid_wr,
    output logic         norm_valid,
    input  logic         norm_ready,
    output logic [31:0]  ptp_pkt_cnt,
    output logic [31:0]  norm_pkt_cnt,
    output logic [31:0]  err_cnt
);
    state_t         r_state, w_nx_state;
    logic [W-1:0]   r_hold, w_nx_hold, w_emit_data;
    logic           r_dec, r_ptp, w_nx_dec, w_nx_ptp;
    logic           r_owe, r_owe_ptp, r_owe_f0, w_nx_owe, w_nx_owe_ptp, w_nx_owe_f0;
    logic           r_pend, r_pend_val;
    logic           w_head, w_tail, w_fire, w_emit, w_emit_ptp, w_err, w_load;
    logic           w_cls_dec, w_cls_ptp, w_desc_val;
    logic           r_in_ready, r_pdwr, r_pvwr, r_pv, r_ndwr, r_nvwr, r_nv;
    logic [W-1:0]   r_pd, r_nd;
    logic [31:0]    r_pcnt, r_ncnt, r_ecnt;

    assign w_head = in_data_wr & (in_data[POS_MSB:POS_LSB] == POS_HEAD);
    assign w_tail = in_data_wr & (in_data[POS_MSB:POS_LSB] == POS_TAIL);
    // A descriptor is owed after a tail or truncation; truncations need no upstream descriptor
    assign w_fire = r_owe & (r_owe_f0 | r_pend | in_valid_wr);
    assign w_desc_val = ~r_owe_f0 & (r_pend ? r_pend_val : in_valid);

    ptp_etype_classify #(.PTP_ETYPE(PTP_ETYPE), .VLAN_TPID(VLAN_TPID)) u_cls (
        .i_etype   (in_data[ETYPE_LSB +: 16]),
        .i_vtype   (in_data[VTYPE_LSB +: 16]),
        .i_idx     (in_data[POS_MSB:POS_LSB] != POS_HEAD),
        .o_decided (w_cls_dec),
        .o_is_ptp  (w_cls_ptp)
    );

    // Next-state, hold update and emit selection
    always_comb begin
        w_nx_state   = r_state;
        w_nx_hold    = r_hold;
        w_nx_dec     = r_dec;
        w_nx_ptp     = r_ptp;
        w_emit       = 1'b0;
        w_emit_ptp   = r_ptp;
        w_emit_data  = r_hold;
        w_nx_owe     = r_owe & ~w_fire;
        w_nx_owe_ptp = r_owe_ptp;
        w_nx_owe_f0  = r_owe_f0;
        w_err        = 1'b0;
        w_load       = 1'b0;
        case (r_state)
            S_IDLE, S_DESC: begin
                if (r_state == S_DESC && w_fire) w_nx_state = S_IDLE;
                w_load = w_head;
                w_err  = in_data_wr & ~w_head;
            end
            S_HEAD, S_BODY: begin
                if (w_head) begin
                    w_emit       = 1'b1;
                    w_emit_ptp   = r_dec & r_ptp;
                    w_emit_data  = {POS_TAIL, r_hold[POS_LSB-1:0]};
                    w_nx_owe     = 1'b1;
                    w_nx_owe_ptp = r_dec & r_ptp;
                    w_nx_owe_f0  = 1'b1;
                    w_err        = 1'b1;
                    w_load       = 1'b1;
                end else if (in_data_wr) begin
                    w_emit     = 1'b1;
                    w_emit_ptp = r_dec ? r_ptp : w_cls_ptp;
                    w_nx_ptp   = w_emit_ptp;
                    w_nx_dec   = 1'b1;
                    w_nx_hold  = in_data;
                    w_nx_state = w_tail ? S_FLUSH : S_BODY;
                end
            end
            S_FLUSH: begin
                w_emit       = 1'b1;
                w_nx_owe     = 1'b1;
                w_nx_owe_ptp = r_ptp;
                w_nx_owe_f0  = 1'b0;
                w_nx_state   = S_DESC;
                w_load       = w_head;
                w_err        = in_data_wr & ~w_head;
            end
            default: w_nx_state = S_IDLE;
        endcase
        if (w_load) begin
            w_nx_hold  = in_data;
            w_nx_dec   = w_cls_dec;
            w_nx_ptp   = w_cls_ptp;
            w_nx_state = S_HEAD;
        end
    end

    // FSM state, hold register and descriptor bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_hold     <= '0;
            r_dec      <= 1'b0;
            r_ptp      <= 1'b0;
            r_owe      <= 1'b0;
            r_owe_ptp  <= 1'b0;
            r_owe_f0   <= 1'b0;
            r_pend     <= 1'b0;
            r_pend_val <= 1'b0;
        end else begin
            r_state   <= w_nx_state;
            r_hold    <= w_nx_hold;
            r_dec     <= w_nx_dec;
            r_ptp     <= w_nx_ptp;
            r_owe     <= w_nx_owe;
            r_owe_ptp <= w_nx_owe_ptp;
            r_owe_f0  <= w_nx_owe_f0;
            if (w_fire) r_pend <= 1'b0;
            else if (in_valid_wr) begin
                r_pend     <= 1'b1;
                r_pend_val <= in_valid;
            end
        end
    end

    // Registered channel outputs, ready and counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_ready <= 1'b0;
            r_pdwr     <= 1'b0;
            r_pd       <= '0;
            r_pvwr     <= 1'b0;
            r_pv       <= 1'b0;
            r_ndwr     <= 1'b0;
            r_nd       <= '0;
            r_nvwr     <= 1'b0;
            r_nv       <= 1'b0;
            r_pcnt     <= '0;
            r_ncnt     <= '0;
            r_ecnt     <= '0;
        end else begin
            r_in_ready <= ptp_ready & norm_ready;
            r_pdwr     <= w_emit & w_emit_ptp;
            r_ndwr     <= w_emit & ~w_emit_ptp;
            if (w_emit & w_emit_ptp) r_pd <= w_emit_data;
            if (w_emit & ~w_emit_ptp) r_nd <= w_emit_data;
            r_pvwr     <= w_fire & r_owe_ptp;
            r_pv       <= w_fire & r_owe_ptp & w_desc_val;
            r_nvwr     <= w_fire & ~r_owe_ptp;
            r_nv       <= w_fire & ~r_owe_ptp & w_desc_val;
            r_pcnt     <= r_pcnt + {31'd0, w_fire & r_owe_ptp};
            r_ncnt     <= r_ncnt + {31'd0, w_fire & ~r_owe_ptp};
            r_ecnt     <= r_ecnt + {31'd0, w_err};
        end
    end

    assign in_ready      = r_in_ready;
    assign ptp_data_wr   = r_pdwr;
    assign ptp_data      = r_pd;
    assign ptp_valid_wr  = r_pvwr;
    assign ptp_valid     = r_pv;
    assign norm_data_wr  = r_ndwr;
    assign norm_data     = r_nd;
    assign norm_valid_wr = r_nvwr;
    assign norm_valid    = r_nv;
    assign ptp_pkt_cnt   = r_pcnt;
    assign norm_pkt_cnt  = r_ncnt;
    assign err_cnt       = r_ecnt;
endmodule

// File: tb/tb_ptp_rx_dispatch.sv
// tb_ptp_rx_dispatch: scoreboard bench for the PTP receive dispatcher
module tb_ptp_rx_dispatch;
    import ptp_pkg::*;

    logic         clk = 1'b0, rst_n = 1'b0;
    logic         in_data_wr = 1'b0, in_valid_wr = 1'b0, in_valid = 1'b0;
    logic [133:0] in_data = '0;
    logic         in_ready, ptp_ready = 1'b1, norm_ready = 1'b1;
    logic         ptp_data_wr, ptp_valid_wr, ptp_valid;
    logic         norm_data_wr, norm_valid_wr, norm_valid;
    logic [133:0] ptp_data, norm_data;
    logic [31:0]  ptp_pkt_cnt, norm_pkt_cnt, err_cnt;

    logic [133:0] q_ptp[$], q_norm[$];
    logic         q_pd[$], q_nd[$];
    logic [133:0] mon_w;
    logic         mon_b;
    int errors = 0, checks = 0;
    int exp_ptp = 0, exp_norm = 0, exp_err = 0;

    always #5 clk = ~clk;

    ptp_rx_dispatch dut (
        .clk(clk), .rst_n(rst_n),
        .in_data_wr(in_data_wr), .in_data(in_data),
        .in_valid_wr(in_valid_wr), .in_valid(in_valid), .in_ready(in_ready),
        .ptp_data_wr(ptp_data_wr), .ptp_data(ptp_data),
        .ptp_valid_wr(ptp_valid_wr), .ptp_valid(ptp_valid), .ptp_ready(ptp_ready),
        .norm_data_wr(norm_data_wr), .norm_data(norm_data),
        .norm_valid_wr(norm_valid_wr), .norm_valid(norm_valid), .norm_ready(norm_ready),
        .ptp_pkt_cnt(ptp_pkt_cnt), .norm_pkt_cnt(norm_pkt_cnt), .err_cnt(err_cnt)
    );

    // Scoreboard: every strobe pops one expectation of its channel
    always @(negedge clk) begin
        if (ptp_data_wr) begin
            checks++;
            if (q_ptp.size() == 0) begin errors++; $display("FAIL ptp_data unexpected got=%h", ptp_data); end
            else begin
                mon_w = q_ptp.pop_front();
                if (ptp_data !== mon_w) begin errors++; $display("FAIL ptp_data got=%h exp=%h", ptp_data, mon_w); end
            end
        end
        if (norm_data_wr) begin
            checks++;
            if (q_norm.size() == 0) begin errors++; $display("FAIL norm_data unexpected got=%h", norm_data); end
            else begin
                mon_w = q_norm.pop_front();
                if (norm_data !== mon_w) begin errors++; $display("FAIL norm_data got=%h exp=%h", norm_data, mon_w); end
            end
        end
        if (ptp_valid_wr) begin
            checks++;
            if (q_pd.size() == 0) begin errors++; $display("FAIL ptp_desc unexpected valid=%b", ptp_valid); end
            else begin
                mon_b = q_pd.pop_front();
                if (ptp_valid !== mon_b) begin errors++; $display("FAIL ptp_valid got=%b exp=%b", ptp_valid, mon_b); end
            end
        end
        if (norm_valid_wr) begin
            checks++;
            if (q_nd.size() == 0) begin errors++; $display("FAIL norm_desc unexpected valid=%b", norm_valid); end
            else begin
                mon_b = q_nd.pop_front();
                if (norm_valid !== mon_b) begin errors++; $display("FAIL norm_valid got=%b exp=%b", norm_valid, mon_b); end
            end
        end
    end

    function automatic logic [133:0] mkw(input logic [1:0] pos);
        mkw = {pos, (pos == POS_TAIL) ? 4'd3 : 4'd0, $urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic push_desc(input int ch, input logic v);
        if (ch == 1) begin q_pd.push_back(v); exp_ptp++; end
        else begin q_nd.push_back(v); exp_norm++; end
    endtask

    // ch: 0 normal, 1 PTP, 2 no word expectation
    task automatic send(input logic [133:0] w, input int ch, input logic vwr, input logic v);
        @(negedge clk);
        in_data_wr = 1'b1; in_data = w; in_valid_wr = vwr; in_valid = v;
        if (ch == 1) q_ptp.push_back(w);
        else if (ch == 0) q_norm.push_back(w);
        if (vwr) push_desc(ch, v);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_data_wr = 1'b0; in_valid_wr = 1'b0;
        end
    endtask

    task automatic send_frame(input logic [15:0] et, input logic [15:0] vt, input int n,
                              input int ch, input logic vwr, input logic v);
        logic [133:0] w;
        w = mkw(POS_HEAD); w[31:16] = et; send(w, ch, 1'b0, 1'b0);
        w = mkw(n == 2 ? POS_TAIL : POS_MID); w[127:112] = vt;
        send(w, ch, n == 2 ? vwr : 1'b0, v);
        for (int i = 2; i < n; i++) send(mkw(i == n - 1 ? POS_TAIL : POS_MID), ch, i == n - 1 ? vwr : 1'b0, v);
    endtask

    task automatic check_end(input string name);
        idle(6);
        checks++;
        if (q_ptp.size() + q_norm.size() + q_pd.size() + q_nd.size() != 0) begin
            errors++; $display("FAIL %s leftover got=%0d exp=0", name, q_ptp.size() + q_norm.size() + q_pd.size() + q_nd.size());
        end
        checks++;
        if (ptp_pkt_cnt !== exp_ptp) begin errors++; $display("FAIL %s ptp_pkt_cnt got=%0d exp=%0d", name, ptp_pkt_cnt, exp_ptp); end
        checks++;
        if (norm_pkt_cnt !== exp_norm) begin errors++; $display("FAIL %s norm_pkt_cnt got=%0d exp=%0d", name, norm_pkt_cnt, exp_norm); end
        checks++;
        if (err_cnt !== exp_err) begin errors++; $display("FAIL %s err_cnt got=%0d exp=%0d", name, err_cnt, exp_err); end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({in_ready, ptp_data_wr, ptp_valid_wr, ptp_valid, norm_data_wr, norm_valid_wr, norm_valid} !== 7'd0 ||
            ptp_data !== '0 || norm_data !== '0) begin
            errors++; $display("FAIL reset strobes/data got=%b exp=0", {in_ready, ptp_data_wr, ptp_valid_wr, norm_data_wr, norm_valid_wr});
        end
        checks++;
        if (ptp_pkt_cnt !== 0 || norm_pkt_cnt !== 0 || err_cnt !== 0) begin
            errors++; $display("FAIL reset counters got=%0d/%0d/%0d exp=0", ptp_pkt_cnt, norm_pkt_cnt, err_cnt);
        end
        rst_n = 1'b1;
        idle(2);
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_ptp_untagged();
        send_frame(16'h88F7, 16'h1234, 4, 1, 1'b1, 1'b1);
        check_end("ptp_untagged");
    endtask

    task automatic test_vlan();
        send_frame(16'h8100, 16'h88F7, 3, 1, 1'b1, 1'b1);
        check_end("vlan_ptp");
        send_frame(16'h8100, 16'h0800, 3, 0, 1'b1, 1'b1);
        check_end("vlan_norm");
    endtask

    task automatic test_late_desc();
        send_frame(16'h0800, 16'h0000, 3, 0, 1'b0, 1'b0);
        idle(3);
        @(negedge clk);
        in_valid_wr = 1'b1; in_valid = 1'b0;
        push_desc(0, 1'b0);
        @(negedge clk);
        in_valid_wr = 1'b0;
        checks++;
        if (norm_valid_wr !== 1'b1 || norm_valid !== 1'b0) begin
            errors++; $display("FAIL late_desc wr/valid got=%b%b exp=10", norm_valid_wr, norm_valid);
        end
        check_end("late_desc");
    endtask

    task automatic test_error_head();
        logic [133:0] w;
        w = mkw(POS_HEAD); w[31:16] = 16'h88F7; send(w, 1, 1'b0, 1'b0);
        send(mkw(POS_MID), 1, 1'b0, 1'b0);
        w = mkw(POS_MID); send(w, 2, 1'b0, 1'b0);
        q_ptp.push_back({POS_TAIL, w[131:0]});
        push_desc(1, 1'b0);
        exp_err++;
        send_frame(16'h8100, 16'h88F7, 3, 1, 1'b1, 1'b1);
        check_end("error_head");
    endtask

    task automatic test_ready_idle();
        @(negedge clk);
        ptp_ready = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL ready early drop got=%b exp=1", in_ready); end
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL ready low got=%b exp=0", in_ready); end
        ptp_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL ready high got=%b exp=1", in_ready); end
        send(mkw(POS_MID), 2, 1'b0, 1'b0);
        exp_err++;
        check_end("mid_in_idle");
    endtask

    task automatic test_reset_mid();
        logic [133:0] w;
        w = mkw(POS_HEAD); w[31:16] = 16'h88F7; send(w, 1, 1'b0, 1'b0);
        send(mkw(POS_MID), 2, 1'b0, 1'b0);
        @(negedge clk);
        in_data = mkw(POS_MID); in_valid_wr = 1'b1; in_valid = 1'b1;
        #2 rst_n = 1'b0;
        exp_ptp = 0; exp_norm = 0; exp_err = 0;
        #1;
        checks++;
        if ({ptp_data_wr, ptp_valid_wr, norm_data_wr, norm_valid_wr, in_ready} !== 5'd0 || err_cnt !== 0 || ptp_pkt_cnt !== 0) begin
            errors++; $display("FAIL reset_mid outputs got=%b exp=0", {ptp_data_wr, ptp_valid_wr, norm_data_wr, norm_valid_wr, in_ready});
        end
        idle(3);
        rst_n = 1'b1;
        idle(2);
        check_end("reset_mid");
        send_frame(16'h88F7, 16'h0000, 4, 1, 1'b1, 1'b1);
        check_end("after_reset");
    endtask

    initial begin
        test_reset();
        test_ptp_untagged();
        test_vlan();
        test_late_desc();
        test_error_head();
        test_ready_idle();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
